// File: rtl/instr_fetch_unit.sv
// Fetch stage: holds the PC, fetches words over req/ack and buffers one instruction for decode.
// Optional IFU_STALL_COUNT_EN adds stall_cnt_o, a saturating count of un-acked request cycles.
module instr_fetch_unit #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [31:0]       imem_data_i,
  output logic [31:0]       instr_o,
  output logic              instr_valid_o,
  input  logic              instr_ready_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] pc_plus4_o,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i
`ifdef IFU_STALL_COUNT_EN
  ,
  output logic [15:0]       stall_cnt_o
`endif
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_FULL  = 2'd1,
    ST_DROP  = 2'd2
  } state_e;

  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);
  localparam logic [ADDR_W-1:0] PC_STEP   = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] START_PC  = RESET_PC & WORD_MASK;

  state_e            state_q, state_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] target_q, target_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] redirect_tgt;
  logic              ack_taken;

  assign redirect_tgt = redirect_pc_i & WORD_MASK;
  // An ack only counts against a request that is actually on the bus.
  assign ack_taken    = req_q && imem_ack_i;

  // Decode handshake: an instruction transfers on a cycle with instr_valid_o && instr_ready_i.
  // Once valid is high, instr_o/pc_o hold until that transfer or until a redirect drops them.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    target_d   = target_q;
    instr_d    = instr_q;
    pc_d       = pc_q;
    valid_d    = valid_q;

    unique case (state_q)
      ST_FETCH: begin
        if (redirect_i) begin
          if (req_q && !imem_ack_i) begin
            target_d = redirect_tgt;
            state_d  = ST_DROP;
          end else begin
            fetch_pc_d = redirect_tgt;
          end
        end else if (ack_taken) begin
          instr_d    = imem_data_i;
          pc_d       = fetch_pc_q;
          valid_d    = 1'b1;
          fetch_pc_d = fetch_pc_q + PC_STEP;
          state_d    = ST_FULL;
        end
      end
      ST_FULL: begin
        if (redirect_i) begin
          valid_d    = 1'b0;
          fetch_pc_d = redirect_tgt;
          state_d    = ST_FETCH;
        end else if (instr_ready_i) begin
          valid_d = 1'b0;
          state_d = ST_FETCH;
        end
      end
      ST_DROP: begin
        // The stale request must complete before the saved target can be fetched.
        if (redirect_i) begin
          target_d = redirect_tgt;
        end
        if (ack_taken) begin
          fetch_pc_d = redirect_i ? redirect_tgt : target_q;
          state_d    = ST_FETCH;
        end
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase

    req_d = (state_d != ST_FULL);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= ST_FETCH;
      req_q      <= 1'b0;
      fetch_pc_q <= START_PC;
      target_q   <= '0;
      instr_q    <= '0;
      pc_q       <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      fetch_pc_q <= fetch_pc_d;
      target_q   <= target_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
    end
  end

  assign imem_req_o    = req_q;
  assign imem_addr_o   = fetch_pc_q;
  assign instr_o       = instr_q;
  assign instr_valid_o = valid_q;
  assign pc_o          = pc_q;
  assign pc_plus4_o    = pc_q + PC_STEP;

`ifdef IFU_STALL_COUNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (req_q && !imem_ack_i && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: vector table, directed corner sequences, and a randomized run
// checked against an architectural next-PC / memory-content model.
module tb_instr_fetch_unit;

  logic        clk_i;
  logic        rst_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_data_i;
  logic [31:0] instr_o;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;

  logic        req2;
  logic [31:0] addr2;
  logic        ack2;
  logic [31:0] data2;
  logic [31:0] instr2;
  logic        valid2;
  logic        ready2;
  logic [31:0] pc2;
  logic [31:0] pc4_2;
  logic        redir2;
  logic [31:0] rpc2;

`ifdef IFU_STALL_COUNT_EN
  logic [15:0] stall_cnt_o;
  logic [15:0] stall2;
`endif

  instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ack_i(imem_ack_i), .imem_data_i(imem_data_i),
    .instr_o(instr_o), .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
    .pc_o(pc_o), .pc_plus4_o(pc_plus4_o),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i)
`ifdef IFU_STALL_COUNT_EN
    , .stall_cnt_o(stall_cnt_o)
`endif
  );

  instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk_i(clk_i), .rst_i(rst_i),
    .imem_req_o(req2), .imem_addr_o(addr2),
    .imem_ack_i(ack2), .imem_data_i(data2),
    .instr_o(instr2), .instr_valid_o(valid2), .instr_ready_i(ready2),
    .pc_o(pc2), .pc_plus4_o(pc4_2),
    .redirect_i(redir2), .redirect_pc_i(rpc2)
`ifdef IFU_STALL_COUNT_EN
    , .stall_cnt_o(stall2)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%08h expected=%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Stall reference: cycles where a request sits on the bus without an ack.
  int exp_stall;
  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) exp_stall <= 0;
    else if (imem_req_o && !imem_ack_i && exp_stall < 65535) exp_stall <= exp_stall + 1;
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic        ack;
    logic [31:0] data;
    logic        ready;
    logic        redir;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic ack, input logic [31:0] data, input logic ready,
                         input logic redir, input logic [31:0] rpc,
                         input logic e_req, input logic [31:0] e_addr, input logic e_valid,
                         input logic [31:0] e_instr, input logic [31:0] e_pc);
    vec_t v;
    v.ack = ack; v.data = data; v.ready = ready; v.redir = redir; v.rpc = rpc;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_instr = e_instr; v.e_pc = e_pc;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic ack, input logic [31:0] data, input logic ready,
                       input logic redir, input logic [31:0] rpc);
    imem_ack_i    = ack;
    imem_data_i   = data;
    instr_ready_i = ready;
    redirect_i    = redir;
    redirect_pc_i = rpc;
  endtask

  task automatic chk_bus(input string name, input logic e_req, input logic [31:0] e_addr,
                         input logic e_valid);
    chk({name, "_req"}, 32'(imem_req_o), 32'(e_req));
    chk({name, "_addr"}, imem_addr_o, e_addr);
    chk({name, "_valid"}, 32'(instr_valid_o), 32'(e_valid));
  endtask

  // ---------------- random-phase state ----------------
  logic [31:0] exp_pc;
  logic [31:0] tgt;
  logic        r_ack, r_ready, r_redir;
  logic        prev_valid, prev_ready, prev_redir;
  int          delivered;

  initial begin
    rst_i = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    ack2 = 1'b0; data2 = 32'h0; ready2 = 1'b1; redir2 = 1'b0; rpc2 = 32'h0;
    step();
    step();

    // Reset state
    chk("rst_req", 32'(imem_req_o), 32'h0);
    chk("rst_addr", imem_addr_o, 32'h0);
    chk("rst_valid", 32'(instr_valid_o), 32'h0);
    chk("rst_instr", instr_o, 32'h0);
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_pc4", pc_plus4_o, 32'h4);
    chk("rst_wrap_addr", addr2, 32'hFFFF_FFFC);
    chk("rst_wrap_req", 32'(req2), 32'h0);
`ifdef IFU_STALL_COUNT_EN
    chk("rst_stall", 32'(stall_cnt_o), 32'h0);
`endif
    rst_i = 1'b1;

    // Cycle table: first fetch, decode stall, drain, redirect with ready, redirect with ack
    add_vec(1'b0, 32'h0,         1'b0, 1'b0, 32'h0,   1'b1, 32'h000, 1'b0, 32'h0,         32'h0);
    add_vec(1'b1, 32'h2001_0005, 1'b0, 1'b0, 32'h0,   1'b0, 32'h004, 1'b1, 32'h2001_0005, 32'h0);
    for (int k = 0; k < 5; k++)
      add_vec(1'b0, 32'h0,       1'b0, 1'b0, 32'h0,   1'b0, 32'h004, 1'b1, 32'h2001_0005, 32'h0);
    add_vec(1'b0, 32'h0,         1'b1, 1'b0, 32'h0,   1'b1, 32'h004, 1'b0, 32'h0,         32'h0);
    add_vec(1'b1, 32'h0C00_0001, 1'b0, 1'b0, 32'h0,   1'b0, 32'h008, 1'b1, 32'h0C00_0001, 32'h4);
    add_vec(1'b0, 32'h0,         1'b1, 1'b0, 32'h0,   1'b1, 32'h008, 1'b0, 32'h0,         32'h0);
    add_vec(1'b1, 32'hAC22_0008, 1'b0, 1'b0, 32'h0,   1'b0, 32'h00C, 1'b1, 32'hAC22_0008, 32'h8);
    add_vec(1'b0, 32'h0,         1'b1, 1'b1, 32'h43,  1'b1, 32'h040, 1'b0, 32'h0,         32'h0);
    add_vec(1'b1, 32'h1111_1111, 1'b0, 1'b0, 32'h0,   1'b0, 32'h044, 1'b1, 32'h1111_1111, 32'h40);
    add_vec(1'b0, 32'h0,         1'b1, 1'b0, 32'h0,   1'b1, 32'h044, 1'b0, 32'h0,         32'h0);
    add_vec(1'b1, 32'h5555_5555, 1'b0, 1'b1, 32'h102, 1'b1, 32'h100, 1'b0, 32'h0,         32'h0);
    add_vec(1'b0, 32'h0,         1'b0, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h0,         32'h0);
    add_vec(1'b1, 32'h2222_2222, 1'b1, 1'b0, 32'h0,   1'b0, 32'h104, 1'b1, 32'h2222_2222, 32'h100);
    add_vec(1'b0, 32'h0,         1'b1, 1'b0, 32'h0,   1'b1, 32'h104, 1'b0, 32'h0,         32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].ack, vecs[i].data, vecs[i].ready, vecs[i].redir, vecs[i].rpc);
      step();
      chk_bus($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_valid);
      if (vecs[i].e_valid) begin
        chk($sformatf("vec%0d_instr", i), instr_o, vecs[i].e_instr);
        chk($sformatf("vec%0d_pc", i), pc_o, vecs[i].e_pc);
        chk($sformatf("vec%0d_pc4", i), pc_plus4_o, vecs[i].e_pc + 32'h4);
      end
    end

    // Redirect while a request is outstanding: stale word must be swallowed
    drive(1'b1, 32'hBAD0_0000, 1'b0, 1'b1, 32'h4);
    step();
    chk_bus("drop_setup", 1'b1, 32'h4, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h80);
    step();
    chk_bus("drop_c0", 1'b1, 32'h4, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    step();
    chk_bus("drop_c1", 1'b1, 32'h4, 1'b0);
    step();
    chk_bus("drop_c2", 1'b1, 32'h4, 1'b0);
    drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
    step();
    chk_bus("drop_ack", 1'b1, 32'h80, 1'b0);
    drive(1'b1, 32'h3333_3333, 1'b0, 1'b0, 32'h0);
    step();
    chk_bus("drop_new", 1'b0, 32'h84, 1'b1);
    chk("drop_new_instr", instr_o, 32'h3333_3333);
    chk("drop_new_pc", pc_o, 32'h80);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    step();
    chk_bus("drop_drain", 1'b1, 32'h84, 1'b0);

    // Newer redirects while dropping overwrite the saved target
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h200);
    step();
    chk_bus("redrop_c0", 1'b1, 32'h84, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h300);
    step();
    chk_bus("redrop_c1", 1'b1, 32'h84, 1'b0);
    drive(1'b1, 32'hDEAD_0001, 1'b0, 1'b1, 32'h401);
    step();
    chk_bus("redrop_ack", 1'b1, 32'h400, 1'b0);

    // Randomized run against the architectural next-PC model
    exp_pc = 32'h0;
    delivered = 0;
    prev_valid = 1'b0; prev_ready = 1'b0; prev_redir = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (c > 0) begin
        chk("rnd_align", imem_addr_o & 32'h3, 32'h0);
        if (prev_valid && !prev_ready && !prev_redir)
          chk("rnd_hold_valid", 32'(instr_valid_o), 32'h1);
        if (instr_valid_o) begin
          chk("rnd_pc", pc_o, exp_pc);
          chk("rnd_instr", instr_o, mem_word(exp_pc));
          chk("rnd_pc4", pc_plus4_o, exp_pc + 32'h4);
          chk("rnd_req_full", 32'(imem_req_o), 32'h0);
        end
      end
      r_ack   = imem_req_o && ($urandom_range(0, 2) == 0);
      r_ready = ($urandom_range(0, 1) == 1);
      r_redir = (c == 0) || ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      else tgt = 32'h0000_1000 + 32'($urandom_range(0, 255));
      drive(r_ack, r_ack ? mem_word(imem_addr_o) : $urandom, r_ready, r_redir, tgt);
      if (r_redir) begin
        exp_pc = tgt & 32'hFFFF_FFFC;
      end else if (instr_valid_o && r_ready) begin
        exp_pc = exp_pc + 32'h4;
        delivered++;
      end
      prev_valid = instr_valid_o;
      prev_ready = r_ready;
      prev_redir = r_redir;
      step();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    step();
    checks++;
    if (delivered < 100) begin
      errors++;
      $display("FAIL rnd_delivered actual=%0d expected>=100", delivered);
    end
`ifdef IFU_STALL_COUNT_EN
    chk("rnd_stall", 32'(stall_cnt_o), 32'(exp_stall));
`endif

    // Wrap-around reset PC
    rst_i = 1'b0;
    step();
    rst_i = 1'b1;
    step();
    chk("wrap_req", 32'(req2), 32'h1);
    chk("wrap_addr0", addr2, 32'hFFFF_FFFC);
    ack2 = 1'b1; data2 = 32'h8C41_0000;
    step();
    ack2 = 1'b0;
    chk("wrap_valid", 32'(valid2), 32'h1);
    chk("wrap_pc", pc2, 32'hFFFF_FFFC);
    chk("wrap_pc4", pc4_2, 32'h0);
    chk("wrap_instr", instr2, 32'h8C41_0000);
    step();
    chk("wrap_req2", 32'(req2), 32'h1);
    chk("wrap_addr1", addr2, 32'h0);

    // Two fetches with three-cycle ack latency, then reset mid-request
    rst_i = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    step();
    rst_i = 1'b1;
    step();
    for (int f = 0; f < 2; f++) begin
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      repeat (3) step();
      drive(1'b1, mem_word(32'(f * 4)), 1'b0, 1'b0, 32'h0);
      step();
      chk($sformatf("lat_valid%0d", f), 32'(instr_valid_o), 32'h1);
      chk($sformatf("lat_pc%0d", f), pc_o, 32'(f * 4));
      drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      step();
    end
`ifdef IFU_STALL_COUNT_EN
    chk("lat_stall", 32'(stall_cnt_o), 32'd6);
`endif
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    step();
    chk("mid_req_before", 32'(imem_req_o), 32'h1);
    #2 rst_i = 1'b0;
    #1;
    chk("mid_rst_req", 32'(imem_req_o), 32'h0);
    chk("mid_rst_addr", imem_addr_o, 32'h0);
`ifdef IFU_STALL_COUNT_EN
    chk("mid_rst_stall", 32'(stall_cnt_o), 32'h0);
`endif
    step();
    rst_i = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
